dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port, synchronous-read data memory between the processor's load/store stage (port 0) and a debug/loader port (port 1). It sits between `seq_processor`'s memory interface and the data memory instance. Accepted requests are sequenced through a three-state FSM, and every accepted access returns exactly one response pulse to its requester.

## Interface
- `ADDR_W`, default 10, word address width.
- `DATA_W`, default 32, data width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`/`req1`  in  1  access request, per port.
- `we0`/`we1`  in  1  1 = write, 0 = read.
- `addr0`/`addr1`  in  ADDR_W  word address.
- `wdata0`/`wdata1`  in  DATA_W  write data.
- `wstrb0`/`wstrb1`  in  DATA_W/8  byte write enables; ignored on reads.
- `gnt0`/`gnt1`  out  1  combinational one-cycle accept pulse.
- `resp0`/`resp1`  out  1  one-cycle completion pulse, for reads and writes.
- `rdata0`/`rdata1`  out  DATA_W  read data; valid only with `resp` on a read; 0 otherwise.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_wstrb`  out  DATA_W/8  memory byte enables.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after `mem_en` with `mem_we`=0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - With any `req`, the arbiter picks a winner and asserts that port's `gnt` in the same cycle.
  - The winner's `we`/`addr`/`wdata`/`wstrb` and port index are registered, and the FSM moves to ISSUE.
  - With no `req`, the FSM stays in IDLE.
- **ISSUE**
  - `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata`/`mem_wstrb` come from the registered command.
  - No grants are issued. The FSM always moves to RESP.
- **RESP**
  - The registered winner's `resp` is 1. On a read, its `rdata` = `mem_rdata`.
  - Grant logic is active exactly as in IDLE. With any `req`, the FSM moves to ISSUE (back-to-back); with none, it moves to IDLE.
- **Requester rules**
  - A requester holds `req` and its command fields stable until the cycle `gnt` is high.
  - A `req` still high in the cycle after `gnt` is a new request.
  - `req` may drop without `gnt`; the request is then withdrawn and nothing is recorded.
- **Arbitration**
  - If only one port requests, that port wins.
  - A tie is resolved per Configuration.
  - `last_grant` updates on every grant.
- **Quiet outputs:** `gnt0` and `gnt1` are never high together. Memory outputs are 0 outside ISSUE.
- **Reset**
  - Reset values: FSM = IDLE, `last_grant` = 1, every output 0.
  - Reset mid-access aborts the access: no `resp` is issued, and a write in ISSUE that coincides with reset is not guaranteed to land.

## Timing
- **Latency:** `gnt` in cycle N, `mem_en` in N+1, `resp`/`rdata` in N+2.
- **Throughput:** at most one access per 2 cycles. A new `gnt` may coincide with the previous `resp`.
- **Grant timing:** `gnt` is combinational from `req`, the FSM state and `last_grant`. There is no path from `mem_rdata` to `gnt`.
- **Response:** `rdata` is a combinational pass-through of `mem_rdata` during RESP, gated by port and read-type.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin on ties. The port opposite `last_grant` wins, so after reset port 0 wins the first tie. Neither port waits more than one access while requesting continuously.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. Port 1 can starve. `last_grant` is still maintained but unused.

## Structure
- **Shared package `dmem_arb_pkg`:**
  - FSM state encoding constants `ST_IDLE`=2'd0, `ST_ISSUE`=2'd1, `ST_RESP`=2'd2.
  - Port index constants `PORT_CPU`=0, `PORT_DBG`=1.
- **Sub-module `dmem_arb_pick`:** the combinational 2-way picker. Inputs are `req0`, `req1`, `last_grant` and `enable`; outputs are the one-hot grant and the winner index. The `DMEM_ARB_RR_EN` selection lives only here.

## Test plan
- **Single read:** port 0 reads addr 0x004 holding 0xDEADBEEF → `gnt0` in N, `mem_en`=1/`mem_we`=0/`mem_addr`=0x004 in N+1, `resp0`=1 with `rdata0`=0xDEADBEEF in N+2, `busy` 1 for N+1..N+2.
- **Write then read:** port 1 writes 0x0000_00A5 with `wstrb`=4'b0001 to addr 0x010, then reads it → `mem_wstrb`=0001 in ISSUE, later `rdata1`=0x0000_00A5, and `resp0` never fires.
- **Tie with `DMEM_ARB_RR_EN`:** both ports hold `req` continuously → grants alternate 0,1,0,1 on cycles N, N+2, N+4, N+6.
- **Tie without `DMEM_ARB_RR_EN`:** both ports hold `req` for 8 cycles → only `gnt0` fires (4 times) and port 1 receives nothing.
- **Reset mid-access:** reset asserted in the RESP cycle of a read → no `resp` afterwards; next cycle FSM = IDLE and all outputs 0; the first post-reset tie goes to port 0.
- **Withdrawn request:** port 1 raises `req` for one cycle during ISSUE, then drops it → no `gnt1`; FSM returns RESP→IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter slice. It holds the FSM
//   state encoding and the port index constants.
//   Used by dmem_arbiter and dmem_arb_pick.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;   // load/store stage of seq_processor
    localparam logic PORT_DBG = 1'b1;   // debug / loader port

    // Returns the one-hot grant vector for a winner index.
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DBG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundle of every handshake and memory-side signal of dmem_arbiter.
//   Requester side : req/we/addr/wdata/wstrb in, gnt/resp/rdata out (x2 ports)
//   Memory side    : mem_en/mem_we/mem_addr/mem_wdata/mem_wstrb out, mem_rdata in
//   Status         : busy out
//   The slave modport is taken by the arbiter. The master modport is taken by
//   the surrounding system (requesters + memory).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              req0,   req1;
    logic              we0,    we1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [STRB_W-1:0] wstrb0, wstrb1;
    logic              gnt0,   gnt1;
    logic              resp0,  resp1;
    logic [DATA_W-1:0] rdata0, rdata1;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1,
               wdata0, wdata1, wstrb0, wstrb1, mem_rdata,
        output gnt0, gnt1, resp0, resp1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1,
               wdata0, wdata1, wstrb0, wstrb1, mem_rdata,
        input  gnt0, gnt1, resp0, resp1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
//   Combinational 2-way picker.
//   Inputs : req0, req1    - per-port request
//            last_grant    - port index of the most recent grant
//            enable        - grants are allowed in this cycle
//   Outputs: gnt[1:0]      - one-hot grant (bit n = port n)
//            winner        - index of the granted port (meaningful when |gnt)
//   Build option DMEM_ARB_RR_EN:
//     defined   - ties go to the port opposite last_grant (round-robin)
//     undefined - ties always go to port 0 (fixed priority)
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       winner
);

`ifndef DMEM_ARB_RR_EN
    // Fixed priority keeps last_grant only for interface uniformity.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        gnt    = '0;
        winner = PORT_CPU;
        if (enable) begin
            if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
                winner = (last_grant == PORT_CPU) ? PORT_DBG : PORT_CPU;
`else
                winner = PORT_CPU;
`endif
                gnt = port_onehot(winner);
            end else if (req0) begin
                winner = PORT_CPU;
                gnt    = port_onehot(PORT_CPU);
            end else if (req1) begin
                winner = PORT_DBG;
                gnt    = port_onehot(PORT_DBG);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port, synchronous-read data memory between the processor
//   load/store stage (port 0) and a debug/loader port (port 1). Each accepted
//   request goes IDLE/RESP -> ISSUE -> RESP and returns one resp pulse.
//   Ports:
//     clk   - system clock, rising edge
//     reset - synchronous, active-high
//     bus   - dmem_arbiter_if.slave: requester handshakes, memory strobes,
//             and busy
//   Build option DMEM_ARB_RR_EN (see dmem_arb_pick): round-robin tie break.
//   Timing: gnt in N (combinational), mem_en in N+1, resp/rdata in N+2.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int STRB_W = DATA_W / 8;

    state_t            state, state_nxt;
    logic              last_grant;

    // Command captured at grant time, replayed to memory in ISSUE.
    logic              cmd_port;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;

    logic              grant_en;
    logic [1:0]        pick_gnt;
    logic              pick_winner;
    logic              any_gnt;
    logic              in_issue;
    logic              in_resp;

    assign in_issue = (state == ST_ISSUE);
    // A reset cycle neither grants nor responds: whatever would be accepted
    // or completed there is discarded by the reset.
    assign in_resp  = (state == ST_RESP) && !reset;
    assign grant_en = ((state == ST_IDLE) || (state == ST_RESP)) && !reset;
    assign any_gnt  = |pick_gnt;

    dmem_arb_pick u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant),
        .enable     (grant_en),
        .gnt        (pick_gnt),
        .winner     (pick_winner)
    );

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (any_gnt) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = any_gnt ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, arbitration history and command registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= PORT_DBG;
            cmd_port   <= PORT_CPU;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_wstrb  <= '0;
        end else begin
            state <= state_nxt;
            if (any_gnt) begin
                last_grant <= pick_winner;
                cmd_port   <= pick_winner;
                if (pick_winner == PORT_DBG) begin
                    cmd_we    <= bus.we1;
                    cmd_addr  <= bus.addr1;
                    cmd_wdata <= bus.wdata1;
                    cmd_wstrb <= bus.wstrb1;
                end else begin
                    cmd_we    <= bus.we0;
                    cmd_addr  <= bus.addr0;
                    cmd_wdata <= bus.wdata0;
                    cmd_wstrb <= bus.wstrb0;
                end
            end
        end
    end

    // Outputs: memory strobes only in ISSUE, responses only in RESP
    always_comb begin
        bus.gnt0      = pick_gnt[0];
        bus.gnt1      = pick_gnt[1];
        bus.busy      = (state != ST_IDLE);

        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (in_issue) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = cmd_we;
            bus.mem_addr  = cmd_addr;
            bus.mem_wdata = cmd_wdata;
            bus.mem_wstrb = cmd_wstrb;
        end

        bus.resp0  = 1'b0;
        bus.resp1  = 1'b0;
        bus.rdata0 = '0;
        bus.rdata1 = '0;
        if (in_resp) begin
            if (cmd_port == PORT_DBG) begin
                bus.resp1 = 1'b1;
                if (!cmd_we) bus.rdata1 = bus.mem_rdata;
            end else begin
                bus.resp0 = 1'b1;
                if (!cmd_we) bus.rdata0 = bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed self-checking bench for dmem_arbiter with a behavioural
//   synchronous-read, byte-strobed memory attached to the memory side.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural data memory
    logic [31:0] mem [0:1023] = '{default: '0};

    always @(posedge clk) begin
        if (reset) begin
            mem[4] <= 32'hDEADBEEF;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b])
                        mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_reqs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    logic [7:0] exp_g0, exp_g1;
    int         g0_cnt, g1_cnt;

    initial begin
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.wstrb0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.wstrb1 = '0;
        bus.mem_rdata = '0;

        // ---- reset state
        nxt(); nxt();
        smp();
        chk("rst_busy",   bus.busy,   0);
        chk("rst_gnt0",   bus.gnt0,   0);
        chk("rst_resp0",  bus.resp0,  0);
        chk("rst_mem_en", bus.mem_en, 0);
        nxt();
        reset = 1'b0;

        // ---- single read, port 0, addr 0x004
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h004;
        smp();
        chk("rd_gnt0", bus.gnt0, 1);
        chk("rd_gnt1", bus.gnt1, 0);
        chk("rd_busy_n", bus.busy, 0);
        nxt(); idle_reqs();
        smp();
        chk("rd_mem_en",   bus.mem_en,   1);
        chk("rd_mem_we",   bus.mem_we,   0);
        chk("rd_mem_addr", bus.mem_addr, 32'h004);
        chk("rd_busy_n1",  bus.busy,     1);
        chk("rd_gnt0_iss", bus.gnt0,     0);
        nxt();
        smp();
        chk("rd_resp0",   bus.resp0,  1);
        chk("rd_rdata0",  bus.rdata0, 32'hDEADBEEF);
        chk("rd_resp1",   bus.resp1,  0);
        chk("rd_rdata1",  bus.rdata1, 0);
        chk("rd_busy_n2", bus.busy,   1);
        chk("rd_mem_en2", bus.mem_en, 0);
        nxt();
        smp();
        chk("rd_busy_n3",  bus.busy,   0);
        chk("rd_resp0_n3", bus.resp0,  0);
        chk("rd_rdata0_n3", bus.rdata0, 0);

        // ---- port 1 write 0xA5 strobe 0001 to 0x010, then back-to-back read
        nxt();
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'h010;
        bus.wdata1 = 32'h000000A5; bus.wstrb1 = 4'b0001;
        smp();
        chk("wr_gnt1", bus.gnt1, 1);
        chk("wr_gnt0", bus.gnt0, 0);
        nxt(); idle_reqs();
        smp();
        chk("wr_mem_en",    bus.mem_en,    1);
        chk("wr_mem_we",    bus.mem_we,    1);
        chk("wr_mem_addr",  bus.mem_addr,  32'h010);
        chk("wr_mem_wdata", bus.mem_wdata, 32'h000000A5);
        chk("wr_mem_wstrb", bus.mem_wstrb, 32'h1);
        nxt();
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h010; bus.wstrb1 = 4'b0000;
        smp();
        chk("wr_resp1",   bus.resp1,  1);
        chk("wr_rdata1",  bus.rdata1, 0);
        chk("wr_resp0",   bus.resp0,  0);
        chk("rb_gnt1",    bus.gnt1,   1);
        nxt(); idle_reqs();
        smp();
        chk("rb_mem_en",   bus.mem_en,   1);
        chk("rb_mem_we",   bus.mem_we,   0);
        chk("rb_mem_addr", bus.mem_addr, 32'h010);
        nxt();
        smp();
        chk("rb_resp1",  bus.resp1,  1);
        chk("rb_rdata1", bus.rdata1, 32'h000000A5);
        chk("rb_resp0",  bus.resp0,  0);
        nxt();

        // ---- tie: both ports request for 8 cycles (last grant was port 1)
`ifdef DMEM_ARB_RR_EN
        exp_g0 = 8'b0001_0001;
        exp_g1 = 8'b0100_0100;
`else
        exp_g0 = 8'b0101_0101;
        exp_g1 = 8'b0000_0000;
`endif
        g0_cnt = 0; g1_cnt = 0;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h004;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h010;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk($sformatf("tie_gnt0_c%0d", i), bus.gnt0, exp_g0[i]);
            chk($sformatf("tie_gnt1_c%0d", i), bus.gnt1, exp_g1[i]);
            g0_cnt += int'(bus.gnt0);
            g1_cnt += int'(bus.gnt1);
            nxt();
        end
        idle_reqs();
`ifdef DMEM_ARB_RR_EN
        chk("tie_cnt0", g0_cnt, 2);
        chk("tie_cnt1", g1_cnt, 2);
        smp();
        chk("tie_last_resp1", bus.resp1, 1);
`else
        chk("tie_cnt0", g0_cnt, 4);
        chk("tie_cnt1", g1_cnt, 0);
        smp();
        chk("tie_last_resp0", bus.resp0, 1);
        chk("tie_no_resp1",   bus.resp1, 0);
`endif
        nxt();
        smp();
        chk("tie_idle", bus.busy, 0);
        nxt();

        // ---- reset asserted in RESP of a port-0 read
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h004;
        smp();
        chk("rr_gnt0", bus.gnt0, 1);
        nxt(); idle_reqs();
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        smp();
        chk("rr_busy",   bus.busy,   0);
        chk("rr_resp0",  bus.resp0,  0);
        chk("rr_rdata0", bus.rdata0, 0);
        chk("rr_mem_en", bus.mem_en, 0);
        chk("rr_gnt0q",  bus.gnt0,   0);
        nxt();
        bus.req0 = 1; bus.req1 = 1;
        smp();
        chk("rr_tie_gnt0", bus.gnt0, 1);
        chk("rr_tie_gnt1", bus.gnt1, 0);
        nxt(); idle_reqs();
        nxt();
        smp();
        chk("rr_post_resp0", bus.resp0, 1);
        nxt();

        // ---- withdrawn request on port 1 during ISSUE
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h004;
        smp();
        chk("wd_gnt0", bus.gnt0, 1);
        nxt();
        bus.req0 = 0; bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h010;
        smp();
        chk("wd_gnt1_iss", bus.gnt1, 0);
        nxt();
        idle_reqs();
        smp();
        chk("wd_gnt1_resp", bus.gnt1,  0);
        chk("wd_resp0",     bus.resp0, 1);
        chk("wd_rdata0",    bus.rdata0, 32'hDEADBEEF);
        nxt();
        smp();
        chk("wd_idle",   bus.busy,   0);
        chk("wd_resp1",  bus.resp1,  0);
        chk("wd_mem_en", bus.mem_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
